// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo
//
// Purpose:
//   Collects retirement (commit) records and drained-store records from a
//   processor core into a circular buffer so that a trace consumer can read
//   them at its own pace. Up to two records are enqueued per cycle. A commit
//   record takes the lower slot and a store record the next slot. Records
//   that do not fit are dropped and counted. A specific store (address/data
//   pair) raises a sticky end-of-simulation flag.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   commit_valid/pc/inst/Ard/data   one retiring instruction per cycle
//   st_commit/st_addr/st_data       one store draining to memory per cycle
//   out_valid/out_ready             head record handshake
//   out_kind (0 commit, 1 store), out_a, out_b, out_rd, out_data, out_seq
//   overflow, drop_cnt  sticky drop flag and saturating drop counter
//   sim_done            sticky end-of-simulation flag
//   commit_cnt          total commit_valid cycles, dropped commits included
module commit_trace_fifo #(
    parameter int          DEPTH        = 16,
    parameter logic [31:0] SIM_END_ADDR = 32'h0000_FFFC,
    parameter logic [31:0] SIM_END_CODE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        commit_valid,
    input  logic [31:0] commit_pc,
    input  logic [31:0] commit_inst,
    input  logic [5:0]  commit_Ard,
    input  logic [31:0] commit_data,
    input  logic        st_commit,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_kind,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [5:0]  out_rd,
    output logic [31:0] out_data,
    output logic [31:0] out_seq,
    output logic        overflow,
    output logic [15:0] drop_cnt,
    output logic        sim_done,
    output logic [63:0] commit_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic        kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rd;
        logic [31:0] data;
        logic [31:0] seq;
    } record_t;

    record_t mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      seq_cnt;

    logic             pop;
    logic [CNT_W-1:0] free_space;
    logic [CNT_W-1:0] store_need;
    logic             commit_acc;
    logic             store_acc;
    logic [1:0]       num_acc;
    logic [1:0]       num_drop;
    logic [16:0]      drop_sum;
    logic [PTR_W-1:0] store_slot;
    record_t          commit_rec;
    record_t          store_rec;
    record_t          head;

    // Space available this cycle includes the slot freed by a simultaneous pop.
    // The store only fits if there is room behind an accepted commit, so a
    // dropped commit always implies a dropped store in the same cycle.
    always_comb begin
        pop        = out_valid && out_ready;
        free_space = CNT_W'(DEPTH) - count + CNT_W'(pop);
        store_need = commit_valid ? CNT_W'(2) : CNT_W'(1);
        commit_acc = commit_valid && (free_space != '0);
        store_acc  = st_commit && (free_space >= store_need);
        num_acc    = {1'b0, commit_acc} + {1'b0, store_acc};
        num_drop   = {1'b0, commit_valid && !commit_acc}
                   + {1'b0, st_commit && !store_acc};
        drop_sum   = {1'b0, drop_cnt} + {15'd0, num_drop};
        store_slot = wr_ptr + PTR_W'(commit_acc);

        commit_rec.kind = 1'b0;
        commit_rec.a    = commit_pc;
        commit_rec.b    = commit_inst;
        commit_rec.rd   = commit_Ard;
        commit_rec.data = commit_data;
        commit_rec.seq  = seq_cnt;

        store_rec.kind  = 1'b1;
        store_rec.a     = st_addr;
        store_rec.b     = '0;
        store_rec.rd    = '0;
        store_rec.data  = st_data;
        store_rec.seq   = seq_cnt + {31'd0, commit_acc};
    end

    // Record storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (commit_acc) begin
            mem[wr_ptr] <= commit_rec;
        end
        if (store_acc) begin
            mem[store_slot] <= store_rec;
        end
    end

    // Pointer, occupancy, sequence and statistics state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            seq_cnt    <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
            sim_done   <= 1'b0;
            commit_cnt <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PTR_W'(num_acc);
            rd_ptr  <= rd_ptr + PTR_W'(pop);
            count   <= count + CNT_W'(num_acc) - CNT_W'(pop);
            seq_cnt <= seq_cnt + 32'(num_acc);
            if (num_drop != 2'd0) begin
                overflow <= 1'b1;
            end
            drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (st_commit && (st_addr == SIM_END_ADDR) && (st_data == SIM_END_CODE)) begin
                sim_done <= 1'b1;
            end
            if (commit_valid) begin
                commit_cnt <= commit_cnt + 64'd1;
            end
        end
    end

    // Head fields are forced to zero whenever nothing is buffered, which also
    // makes them zero immediately when reset clears the occupancy count.
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count != '0);
        out_kind  = out_valid ? head.kind : 1'b0;
        out_a     = out_valid ? head.a    : '0;
        out_b     = out_valid ? head.b    : '0;
        out_rd    = out_valid ? head.rd   : '0;
        out_data  = out_valid ? head.data : '0;
        out_seq   = out_valid ? head.seq  : '0;
    end

endmodule
